ipv4_hdr_check_stage: RTL and testbench
=======================================

Name: ipv4_hdr_check_stage

Overview:
- Stage directly downstream of the output-port-lookup input FIFO stage.
- Inspects the first beat of each packet:
  - Ethernet destination MAC against the ingress port MAC.
  - Ethertype.
  - IPv4 version and TTL.
- Outcome per packet: drop, divert to the paired CPU port, or forward with TTL decremented and the IPv4 checksum incrementally updated.
- Keeps 32-bit event counters for the register block.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, counter and MAC register width.
- C_M_AXIS_DATA_WIDTH, 256, output stream data width; header layout below requires 256.
- C_S_AXIS_DATA_WIDTH, 256, input stream data width; must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128, output TUSER width.
- C_S_AXIS_TUSER_WIDTH, 128, input TUSER width.
- SRC_PORT_POS, 16, LSB of the 8-bit one-hot source-port field in TUSER.
- DST_PORT_POS, 24, LSB of the 8-bit one-hot destination-port field in TUSER.

Ports:
- AXI_ACLK  in  1  clock.
- AXI_RESET  in  1  synchronous reset, active-high.
- S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  256/32/128/1/1  upstream stream.
- S_AXIS_TREADY  out  1  upstream ready.
- M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/128/1/1  downstream stream.
- M_AXIS_TREADY  in  1  downstream ready.
- mac0_low..mac3_low  in  32 each  port MAC bits [31:0].
- mac0_high..mac3_high  in  32 each  port MAC bits [47:32] in [15:0]; upper bits ignored.
- counter_clear  in  1  one-cycle pulse, zeroes all counters.
- wrong_mac_count, non_ip_count, ver_count, bad_ttl_count, cpu_count, fwd_count, dropped_count  out  32 each  event counters.

Behaviour:
- Header fields in beat 0:
  - dst MAC [255:208]; ethertype [159:144]; IP version [143:140]; TTL [79:72]; checksum [63:48].
  - src port = TUSER[SRC_PORT_POS+7:SRC_PORT_POS]; even bits 0/2/4/6 are MAC ports 0-3, odd bits are CPU ports.
- Classification, first match wins:
  1. src port has any odd bit set -> CPU_IN: forward unmodified (DST_PORT field preserved); cpu_count++.
  2. src port is zero or not one-hot -> drop; dropped_count++.
  3. dst MAC is neither the ingress port MAC nor FF:FF:FF:FF:FF:FF -> drop; wrong_mac_count++ and dropped_count++.
  4. ethertype != 16'h0800 -> TO_CPU: DST_PORT = src<<1; non_ip_count++.
  5. version != 4 -> TO_CPU; ver_count++.
  6. TTL <= 1 -> TO_CPU; bad_ttl_count++.
  7. otherwise -> FWD: TTL-1; checksum = ~(~csum + ~16'h0100) with end-around carry (RFC 1624); fwd_count++. DST_PORT passed through for a later lookup stage.
- Only TTL, checksum, and the DST_PORT field are ever modified. Later beats pass unmodified.
- FSM states: HDR, PASS, DROP.
  - HDR: on accepted beat with !TLAST go to PASS, or DROP if the packet is dropped. TLAST on beat 0 stays in HDR.
  - PASS/DROP: return to HDR on accepted TLAST.
- Output register stage:
  - S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY.
  - Latency is 1 cycle from input accept to M_AXIS_TVALID.
  - Output holds stable while TVALID && !TREADY.
- Drop: beats are accepted (TREADY per the rule above) but never loaded into the output register.
- Counters:
  - Increment once per packet, on the beat-0 handshake.
  - Wrap at 2^32.
  - counter_clear wins over a same-cycle increment.
- Reset (takes effect mid-packet too):
  - M_AXIS_TVALID=0, M_AXIS_TDATA/TSTRB/TUSER/TLAST=0, all counters 0, FSM=HDR.
  - The next accepted beat is treated as a header.
- Upstream TVALID low mid-packet: FSM holds state and nothing is emitted.

Decomposition:
- Package ipv4_hdr_check_pkg holds:
  - field bit positions;
  - ETH_IPV4=16'h0800 and BCAST_MAC;
  - FSM state encoding;
  - classification enum {CPU_IN, DROP, TO_CPU, FWD}.
- Sub-module ttl_csum_update: combinational TTL decrement plus RFC 1624 checksum, 8-bit TTL in and 16-bit checksum in/out. Unit-tested separately.

Test Plan:
- Port-0 IPv4 packet, 3 beats, dst MAC = mac0, TTL 64, csum 16'hB1E6 -> forwarded 1 cycle later with TTL 63 and csum 16'hB2E6; fwd_count=1.
- Dst MAC 02:00:00:00:00:99 on port 2 -> no M_AXIS_TVALID for any beat; wrong_mac_count=1, dropped_count=1; next good packet forwarded.
- ARP (16'h0806) on port 1 -> DST_PORT=8'h08; non_ip_count=1. TTL=1 IPv4 on port 3 -> DST_PORT=8'h80; bad_ttl_count=1.
- M_AXIS_TREADY toggled 1/0 each cycle during a 4-beat FWD packet -> all 4 beats delivered in order, none duplicated, output stable while stalled.
- Single-beat packet (TLAST on beat 0) followed back-to-back by a dropped packet -> FSM in HDR for the second packet; counters fwd_count=1, dropped_count=1.
- counter_clear asserted in the same cycle as a beat-0 handshake -> all counters read 0 the next cycle. AXI_RESET mid-packet -> TVALID 0 next cycle and the next beat is parsed as a header.

Source files
------------

// File: rtl/ipv4_hdr_check_pkg.sv
// ============================================================================
// ipv4_hdr_check_pkg : header field positions, constants and encodings | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package ipv4_hdr_check_pkg;

  // Bit positions within the 256-bit first beat of a packet
  localparam int DMAC_LSB  = 208;
  localparam int ETYPE_LSB = 144;
  localparam int VER_LSB   = 140;
  localparam int TTL_LSB   = 72;
  localparam int CSUM_LSB  = 48;

  localparam logic [15:0] ETH_IPV4      = 16'h0800;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
  localparam logic [7:0]  ODD_PORT_MASK = 8'hAA;

  // Event counter indices
  localparam int NUM_CNT       = 7;
  localparam int CNT_WRONG_MAC = 0;
  localparam int CNT_NON_IP    = 1;
  localparam int CNT_VER       = 2;
  localparam int CNT_BAD_TTL   = 3;
  localparam int CNT_CPU       = 4;
  localparam int CNT_FWD       = 5;
  localparam int CNT_DROPPED   = 6;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_CPU_IN = 2'd0,
    CLS_DROP   = 2'd1,
    CLS_TO_CPU = 2'd2,
    CLS_FWD    = 2'd3
  } class_e;

endpackage

`default_nettype wire

// File: rtl/ipv4_hdr_check_stage_ttl_csum_update.sv
// ============================================================================
// ttl_csum_update : TTL decrement with RFC 1624 incremental checksum | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ttl_csum_update
  import ipv4_hdr_check_pkg::*;
(
  input  logic [7:0]  ttl_i,
  input  logic [15:0] csum_i,
  output logic [7:0]  ttl_o,
  output logic [15:0] csum_o
);

  // TTL is the high byte of its 16-bit header word, so the word drops by 0x0100
  localparam logic [15:0] TTL_WORD_DELTA = 16'h0100;

  logic [16:0] sum;
  logic [15:0] folded;

  assign ttl_o  = ttl_i - 8'd1;
  assign sum    = {1'b0, ~csum_i} + {1'b0, ~TTL_WORD_DELTA};
  assign folded = sum[15:0] + {15'd0, sum[16]};
  assign csum_o = ~folded;

endmodule

`default_nettype wire

// File: rtl/ipv4_hdr_check_stage.sv
// ============================================================================
// ipv4_hdr_check_stage : per-packet MAC/ethertype/IPv4 check, TTL update | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ipv4_hdr_check_stage
  import ipv4_hdr_check_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,

  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_high,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_low,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_high,

  input  logic                              counter_clear,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     wrong_mac_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     non_ip_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     ver_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     bad_ttl_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     cpu_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     fwd_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     dropped_count
);

  state_e state_q, state_d;
  class_e cls;

  logic                             m_valid_q, m_valid_d;
  logic                             m_last_q,  m_last_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   m_data_q,  m_data_d;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_strb_q,  m_strb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  m_user_q,  m_user_d;

  logic [C_S_AXI_DATA_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [NUM_CNT-1:0]            cnt_inc;

  logic        s_hs, hdr_beat, load;
  logic [7:0]  src_port;
  logic        src_onehot, mac_ok;
  logic [1:0]  port_idx;
  logic [47:0] port_mac [4];
  logic [47:0] dst_mac;
  logic        wrong_mac, non_ip, bad_ver, bad_ttl;
  logic [7:0]  ttl_dec;
  logic [15:0] csum_upd;
  logic [C_M_AXIS_DATA_WIDTH-1:0]  out_data;
  logic [C_M_AXIS_TUSER_WIDTH-1:0] out_user;

  assign S_AXIS_TREADY = !m_valid_q || M_AXIS_TREADY;
  assign s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign hdr_beat      = s_hs && (state_q == ST_HDR);

  assign port_mac[0] = {mac0_high[15:0], mac0_low};
  assign port_mac[1] = {mac1_high[15:0], mac1_low};
  assign port_mac[2] = {mac2_high[15:0], mac2_low};
  assign port_mac[3] = {mac3_high[15:0], mac3_low};

  logic unused_mac_high;
  assign unused_mac_high = ^{mac0_high[31:16], mac1_high[31:16],
                             mac2_high[31:16], mac3_high[31:16]};

  // Even one-hot bits 0/2/4/6 map to MAC ports 0..3
  assign src_port   = S_AXIS_TUSER[SRC_PORT_POS +: 8];
  assign src_onehot = (src_port != 8'h00) && ((src_port & (src_port - 8'd1)) == 8'h00);
  assign port_idx   = {src_port[4] | src_port[6], src_port[2] | src_port[6]};
  assign dst_mac    = S_AXIS_TDATA[DMAC_LSB +: 48];
  assign mac_ok     = (dst_mac == port_mac[port_idx]) || (dst_mac == BCAST_MAC);

  ttl_csum_update u_ttl_csum (
    .ttl_i  (S_AXIS_TDATA[TTL_LSB +: 8]),
    .csum_i (S_AXIS_TDATA[CSUM_LSB +: 16]),
    .ttl_o  (ttl_dec),
    .csum_o (csum_upd)
  );

  always_comb begin
    cls       = CLS_FWD;
    wrong_mac = 1'b0;
    non_ip    = 1'b0;
    bad_ver   = 1'b0;
    bad_ttl   = 1'b0;
    if (|(src_port & ODD_PORT_MASK)) begin
      cls = CLS_CPU_IN;
    end else if (!src_onehot) begin
      cls = CLS_DROP;
    end else if (!mac_ok) begin
      cls       = CLS_DROP;
      wrong_mac = 1'b1;
    end else if (S_AXIS_TDATA[ETYPE_LSB +: 16] != ETH_IPV4) begin
      cls    = CLS_TO_CPU;
      non_ip = 1'b1;
    end else if (S_AXIS_TDATA[VER_LSB +: 4] != 4'd4) begin
      cls     = CLS_TO_CPU;
      bad_ver = 1'b1;
    end else if (S_AXIS_TDATA[TTL_LSB +: 8] <= 8'd1) begin
      cls     = CLS_TO_CPU;
      bad_ttl = 1'b1;
    end
  end

  always_comb begin
    out_data = S_AXIS_TDATA;
    out_user = S_AXIS_TUSER;
    if (state_q == ST_HDR) begin
      if (cls == CLS_TO_CPU) begin
        out_user[DST_PORT_POS +: 8] = {src_port[6:0], 1'b0};
      end
      if (cls == CLS_FWD) begin
        out_data[TTL_LSB +: 8]   = ttl_dec;
        out_data[CSUM_LSB +: 16] = csum_upd;
      end
    end
  end

  // Packet FSM and output-register next state
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_strb_d  = m_strb_q;
    m_user_d  = m_user_q;
    m_last_d  = m_last_q;
    unique case (state_q)
      ST_HDR: begin
        load = s_hs && (cls != CLS_DROP);
        if (s_hs && !S_AXIS_TLAST) begin
          state_d = (cls == CLS_DROP) ? ST_DROP : ST_PASS;
        end
      end
      ST_PASS: begin
        load = s_hs;
        if (s_hs && S_AXIS_TLAST) state_d = ST_HDR;
      end
      ST_DROP: begin
        if (s_hs && S_AXIS_TLAST) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = out_data;
      m_strb_d  = S_AXIS_TSTRB;
      m_user_d  = out_user;
      m_last_d  = S_AXIS_TLAST;
    end else if (M_AXIS_TREADY) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state_q   <= ST_HDR;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_strb_q  <= '0;
      m_user_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_strb_q  <= m_strb_d;
      m_user_q  <= m_user_d;
      m_last_q  <= m_last_d;
    end
  end

  always_comb begin
    cnt_inc                = '0;
    cnt_inc[CNT_WRONG_MAC] = hdr_beat && wrong_mac;
    cnt_inc[CNT_NON_IP]    = hdr_beat && non_ip;
    cnt_inc[CNT_VER]       = hdr_beat && bad_ver;
    cnt_inc[CNT_BAD_TTL]   = hdr_beat && bad_ttl;
    cnt_inc[CNT_CPU]       = hdr_beat && (cls == CLS_CPU_IN);
    cnt_inc[CNT_FWD]       = hdr_beat && (cls == CLS_FWD);
    cnt_inc[CNT_DROPPED]   = hdr_beat && (cls == CLS_DROP);
  end

  // Clear has priority over a coincident increment
  always_ff @(posedge AXI_ACLK) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (AXI_RESET || counter_clear) begin
        cnt_q[i] <= '0;
      end else if (cnt_inc[i]) begin
        cnt_q[i] <= cnt_q[i] + C_S_AXI_DATA_WIDTH'(1);
      end
    end
  end

  assign M_AXIS_TVALID   = m_valid_q;
  assign M_AXIS_TDATA    = m_data_q;
  assign M_AXIS_TSTRB    = m_strb_q;
  assign M_AXIS_TUSER    = m_user_q;
  assign M_AXIS_TLAST    = m_last_q;

  assign wrong_mac_count = cnt_q[CNT_WRONG_MAC];
  assign non_ip_count    = cnt_q[CNT_NON_IP];
  assign ver_count       = cnt_q[CNT_VER];
  assign bad_ttl_count   = cnt_q[CNT_BAD_TTL];
  assign cpu_count       = cnt_q[CNT_CPU];
  assign fwd_count       = cnt_q[CNT_FWD];
  assign dropped_count   = cnt_q[CNT_DROPPED];

endmodule

`default_nettype wire

// File: tb/tb_ipv4_hdr_check_stage.sv
// ============================================================================
// tb_ipv4_hdr_check_stage : directed scoreboard bench for the header check | rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ipv4_hdr_check_stage;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  localparam logic [47:0]  MAC0  = 48'h0200_0000_0010;
  localparam logic [47:0]  MAC1  = 48'h0200_0000_0011;
  localparam logic [47:0]  MAC2  = 48'h0200_0000_0012;
  localparam logic [47:0]  MAC3  = 48'h0200_0000_0013;
  localparam logic [47:0]  BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [DW-1:0] FILL =
    256'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic          clk;
  logic          AXI_RESET;
  logic [DW-1:0] S_AXIS_TDATA, M_AXIS_TDATA;
  logic [SW-1:0] S_AXIS_TSTRB, M_AXIS_TSTRB;
  logic [UW-1:0] S_AXIS_TUSER, M_AXIS_TUSER;
  logic          S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic          M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic [31:0]   mac0_low, mac0_high, mac1_low, mac1_high;
  logic [31:0]   mac2_low, mac2_high, mac3_low, mac3_high;
  logic          counter_clear;
  logic [31:0]   wrong_mac_count, non_ip_count, ver_count, bad_ttl_count;
  logic [31:0]   cpu_count, fwd_count, dropped_count;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  bit    toggle_rdy = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ipv4_hdr_check_stage dut (
    .AXI_ACLK(clk), .AXI_RESET(AXI_RESET),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .mac0_low(mac0_low), .mac0_high(mac0_high), .mac1_low(mac1_low), .mac1_high(mac1_high),
    .mac2_low(mac2_low), .mac2_high(mac2_high), .mac3_low(mac3_low), .mac3_high(mac3_high),
    .counter_clear(counter_clear),
    .wrong_mac_count(wrong_mac_count), .non_ip_count(non_ip_count), .ver_count(ver_count),
    .bad_ttl_count(bad_ttl_count), .cpu_count(cpu_count), .fwd_count(fwd_count),
    .dropped_count(dropped_count)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input logic [47:0] dm, input logic [15:0] et,
                                        input logic [3:0] ver, input logic [7:0] ttl,
                                        input logic [15:0] cs);
    logic [DW-1:0] h;
    h = FILL;
    h[255:208] = dm;
    h[159:144] = et;
    h[143:140] = ver;
    h[79:72]   = ttl;
    h[63:48]   = cs;
    return h;
  endfunction

  function automatic logic [UW-1:0] usr(input logic [7:0] src, input logic [7:0] dst);
    logic [UW-1:0] u;
    u = {4{32'hA5C3_1E0F}};
    u[23:16] = src;
    u[31:24] = dst;
    return u;
  endfunction

  // RFC 1624 update for a TTL word drop of 0x0100: ~(~HC + ~m + m')
  function automatic logic [15:0] csum_model(input logic [15:0] c);
    logic [16:0] s;
    logic [15:0] f;
    s = {1'b0, ~c} + 17'h0FEFF;
    f = s[15:0] + {15'd0, s[16]};
    return ~f;
  endfunction

  // Scoreboard: every valid output cycle must match the oldest expected beat
  always @(negedge clk) begin
    if (M_AXIS_TVALID === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_beat observed=%0h expected=none", M_AXIS_TDATA);
      end else begin
        chk("out_tdata", M_AXIS_TDATA, sb[0].d);
        chk("out_tuser", M_AXIS_TUSER, sb[0].u);
        chk("out_tstrb", M_AXIS_TSTRB, sb[0].s);
        chk("out_tlast", M_AXIS_TLAST, sb[0].l);
        if (M_AXIS_TREADY) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    counter_clear = 1'b0;
    if (toggle_rdy) M_AXIS_TREADY = !M_AXIS_TREADY;
  endtask

  task automatic send(input beat_t b);
    int n;
    bit hs;
    n  = 0;
    hs = 0;
    S_AXIS_TDATA  = b.d;
    S_AXIS_TSTRB  = b.s;
    S_AXIS_TUSER  = b.u;
    S_AXIS_TLAST  = b.l;
    S_AXIS_TVALID = 1'b1;
    while (!hs) begin
      @(negedge clk);
      hs = S_AXIS_TREADY;
      step();
      n++;
      if (!hs && n > 40) begin
        checks++;
        errors++;
        $error("FAIL send_timeout observed=stalled expected=accept");
        break;
      end
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic pkt(input logic [DW-1:0] d0, input logic [UW-1:0] u0,
                     input logic [DW-1:0] ed0, input logic [UW-1:0] eu0,
                     input bit out, input int n);
    beat_t b, e;
    for (int i = 0; i < n; i++) begin
      b.l = (i == n - 1);
      b.s = b.l ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
      b.u = u0;
      b.d = d0;
      if (i != 0) begin
        for (int j = 0; j < 8; j++) b.d[j*32 +: 32] = $urandom;
      end
      e = b;
      if (i == 0) begin
        e.d = ed0;
        e.u = eu0;
      end
      if (out) sb.push_back(e);
      send(b);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    toggle_rdy    = 0;
    M_AXIS_TREADY = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    step();
  endtask

  task automatic chk_cnt(input int wm, input int ni, input int vr, input int tt,
                         input int cp, input int fw, input int dr);
    chk("wrong_mac_count", wrong_mac_count, wm);
    chk("non_ip_count",    non_ip_count,    ni);
    chk("ver_count",       ver_count,       vr);
    chk("bad_ttl_count",   bad_ttl_count,   tt);
    chk("cpu_count",       cpu_count,       cp);
    chk("fwd_count",       fwd_count,       fw);
    chk("dropped_count",   dropped_count,   dr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [15:0]   cs;
    beat_t         b0, b1, e0, e1;

    AXI_RESET     = 1'b1;
    S_AXIS_TDATA  = '0;
    S_AXIS_TSTRB  = '0;
    S_AXIS_TUSER  = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    M_AXIS_TREADY = 1'b1;
    counter_clear = 1'b0;
    mac0_low = MAC0[31:0]; mac0_high = {16'hDEAD, MAC0[47:32]};
    mac1_low = MAC1[31:0]; mac1_high = {16'hBEEF, MAC1[47:32]};
    mac2_low = MAC2[31:0]; mac2_high = {16'h1234, MAC2[47:32]};
    mac3_low = MAC3[31:0]; mac3_high = {16'hFFFF, MAC3[47:32]};
    repeat (3) step();

    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tdata",  M_AXIS_TDATA,  0);
    chk("rst_tuser",  M_AXIS_TUSER,  0);
    chk("rst_tlast",  M_AXIS_TLAST,  0);
    chk_cnt(0, 0, 0, 0, 0, 0, 0);
    AXI_RESET = 1'b0;
    step();

    // Port-0 IPv4, TTL 64, checksum B1E6 -> TTL 63, checksum B2E6
    u = usr(8'h01, 8'h00);
    pkt(hdr(MAC0, 16'h0800, 4'd4, 8'd64, 16'hB1E6), u,
        hdr(MAC0, 16'h0800, 4'd4, 8'd63, 16'hB2E6), u, 1, 3);
    drain();
    chk_cnt(0, 0, 0, 0, 0, 1, 0);

    // Wrong MAC on port 2 is dropped; a broadcast on port 2 is then forwarded
    pkt(hdr(48'h0200_0000_0099, 16'h0800, 4'd4, 8'd64, 16'h1234), usr(8'h10, 8'h00),
        '0, '0, 0, 3);
    repeat (3) step();
    chk_cnt(1, 0, 0, 0, 0, 1, 1);
    cs = 16'h7A3C;
    u  = usr(8'h10, 8'h00);
    pkt(hdr(BCAST, 16'h0800, 4'd4, 8'd10, cs), u,
        hdr(BCAST, 16'h0800, 4'd4, 8'd9, csum_model(cs)), u, 1, 2);
    drain();
    chk_cnt(1, 0, 0, 0, 0, 2, 1);

    // Divert, CPU-in and bad-source cases
    d = hdr(MAC1, 16'h0806, 4'd4, 8'd64, 16'h0000);
    pkt(d, usr(8'h04, 8'h33), d, usr(8'h04, 8'h08), 1, 2);
    d = hdr(MAC3, 16'h0800, 4'd4, 8'd1, 16'h4321);
    pkt(d, usr(8'h40, 8'h00), d, usr(8'h40, 8'h80), 1, 1);
    d = hdr(MAC0, 16'h0800, 4'd6, 8'd64, 16'h5555);
    pkt(d, usr(8'h01, 8'h00), d, usr(8'h01, 8'h02), 1, 2);
    cs = 16'hFFFF;
    u  = usr(8'h01, 8'h00);
    pkt(hdr(MAC0, 16'h0800, 4'd4, 8'd2, cs), u,
        hdr(MAC0, 16'h0800, 4'd4, 8'd1, csum_model(cs)), u, 1, 1);
    d = hdr(48'h0200_0000_0077, 16'h86DD, 4'd4, 8'd0, 16'h0000);
    u = usr(8'h02, 8'h01);
    pkt(d, u, d, u, 1, 2);
    pkt(hdr(MAC0, 16'h0800, 4'd4, 8'd64, 16'h0000), usr(8'h05, 8'h00), '0, '0, 0, 2);
    pkt(hdr(MAC0, 16'h0800, 4'd4, 8'd64, 16'h0000), usr(8'h00, 8'h00), '0, '0, 0, 1);
    drain();
    chk_cnt(1, 1, 1, 1, 1, 3, 3);

    // Downstream ready toggling every cycle across a 4-beat forwarded packet
    toggle_rdy = 1;
    cs = 16'hFF80;
    u  = usr(8'h04, 8'h00);
    pkt(hdr(MAC1, 16'h0800, 4'd4, 8'd128, cs), u,
        hdr(MAC1, 16'h0800, 4'd4, 8'd127, csum_model(cs)), u, 1, 4);
    drain();
    chk_cnt(1, 1, 1, 1, 1, 4, 3);

    // Standalone clear, then single-beat packet followed by a dropped one
    counter_clear = 1'b1;
    step();
    chk_cnt(0, 0, 0, 0, 0, 0, 0);
    chk("idle_before_single", M_AXIS_TVALID, 0);
    cs = 16'h1111;
    u  = usr(8'h01, 8'h00);
    pkt(hdr(MAC0, 16'h0800, 4'd4, 8'd64, cs), u,
        hdr(MAC0, 16'h0800, 4'd4, 8'd63, csum_model(cs)), u, 1, 1);
    chk("latency_1cyc", M_AXIS_TVALID, 1);
    pkt(hdr(MAC1, 16'h0800, 4'd4, 8'd64, 16'h2222), usr(8'h01, 8'h00), '0, '0, 0, 2);
    d = hdr(MAC0, 16'h0806, 4'd4, 8'd64, 16'h0000);
    pkt(d, usr(8'h01, 8'h00), d, usr(8'h01, 8'h02), 1, 1);
    drain();
    chk_cnt(1, 1, 0, 0, 0, 1, 1);

    // Clear coincident with a beat-0 handshake wins over the increment
    cs   = 16'h0F0F;
    b0.d = hdr(MAC3, 16'h0800, 4'd4, 8'd33, cs);
    b0.s = 32'hFFFF_FFFF;
    b0.u = usr(8'h40, 8'h00);
    b0.l = 1'b0;
    e0   = b0;
    e0.d = hdr(MAC3, 16'h0800, 4'd4, 8'd32, csum_model(cs));
    b1.d = {8{32'hC0DE_F00D}};
    b1.s = 32'h0000_00FF;
    b1.u = b0.u;
    b1.l = 1'b1;
    e1   = b1;
    sb.push_back(e0);
    counter_clear = 1'b1;
    send(b0);
    chk_cnt(0, 0, 0, 0, 0, 0, 0);
    sb.push_back(e1);
    send(b1);
    drain();
    chk("fwd_after_clear", fwd_count, 0);

    // Reset in the middle of a packet; next beat must be parsed as a header
    cs   = 16'hABCD;
    b0.d = hdr(MAC2, 16'h0800, 4'd4, 8'd20, cs);
    b0.u = usr(8'h10, 8'h00);
    b0.l = 1'b0;
    e0   = b0;
    e0.d = hdr(MAC2, 16'h0800, 4'd4, 8'd19, csum_model(cs));
    b1.u = b0.u;
    b1.l = 1'b0;
    e1   = b1;
    sb.push_back(e0);
    send(b0);
    sb.push_back(e1);
    send(b1);
    AXI_RESET = 1'b1;
    step();
    chk("midrst_tvalid", M_AXIS_TVALID, 0);
    chk("midrst_tdata",  M_AXIS_TDATA,  0);
    chk("midrst_fwd",    fwd_count,     0);
    AXI_RESET = 1'b0;
    d = hdr(MAC2, 16'h0806, 4'd4, 8'd64, 16'h0000);
    pkt(d, usr(8'h10, 8'h00), d, usr(8'h10, 8'h20), 1, 1);
    drain();
    chk_cnt(0, 1, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
